matrix_loader: RTL
==================

# matrix_loader

Write-side sequencer for the 8x8 coefficient RAM. Accepts a stream of 64 SIZE-bit words over a valid/ready handshake and drives the RAM write port (W_data, Wi_address, Wj_address, Wen) so that one full matrix is stored, in row-major order by default. It then holds the matrix stable, with no writes, and reports it valid until the column-reading datapath releases it. It sits between the input stream source and the RAM write port; the datapath reads columns from the RAM directly.

## Interface
Parameters:
- SIZE, 16, word width of in_data and W_data

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin loading a new matrix; honoured only in IDLE
- transpose  in  1  fill order select, sampled with start (see Configuration)
- in_data  in  SIZE  stream word
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts a word this cycle
- W_data  out  SIZE  RAM write data (registered)
- Wi_address  out  3  RAM row address (registered)
- Wj_address  out  3  RAM column address (registered)
- Wen  out  1  RAM write enable (registered)
- words_loaded  out  7  words accepted in the current load, 0..64
- matrix_valid  out  1  RAM holds a complete matrix
- release  in  1  consumer has finished with the matrix

## Operation
- FSM states: IDLE, LOAD, FLUSH, FULL.
- IDLE:
  - in_ready=0.
  - start=1 → LOAD; words_loaded←0; transpose latched.
- LOAD:
  - in_ready=1.
  - A transfer occurs on a rising edge where in_valid&in_ready=1.
  - Each transfer registers W_data←in_data, the address pair for index k=words_loaded, and Wen←1, then increments words_loaded.
  - A cycle with no transfer registers Wen←0.
  - The 64th transfer (k=63) → FLUSH.
- Address mapping:
  - Row-major: Wi=k[5:3], Wj=k[2:0].
  - Transposed: Wi=k[2:0], Wj=k[5:3].
- FLUSH:
  - in_ready=0; Wen from the last transfer is on the outputs this cycle.
  - Next edge: Wen←0 → FULL.
- FULL:
  - in_ready=0; matrix_valid=1; Wen=0.
  - release=1 → IDLE; matrix_valid←0; words_loaded is kept at 64 until the next start.
- start outside IDLE is ignored. release outside FULL is ignored.
- Simultaneous start and release in FULL: release is taken → IDLE. start is not remembered.
- in_valid may drop at any time in LOAD. Stalls are unlimited; no timeout.
- W_data and the addresses hold their last value when Wen=0.

## Timing
- Reset (any state, including mid-LOAD):
  - state=IDLE.
  - in_ready=0, Wen=0, W_data=0, Wi_address=0, Wj_address=0.
  - words_loaded=0, matrix_valid=0, latched transpose=0.
  - A partially written matrix is abandoned. RAM contents are not cleared.
- in_ready is decoded from the state register only; it has no combinational path from in_valid.
- Write latency:
  - A word transferred at edge n drives Wen=1 with its data and address during cycle n..n+1.
  - The RAM captures it by edge n+1.
- Throughput: one word per cycle. Minimum load time is start edge + 64 transfer edges + 1 FLUSH edge.
- matrix_valid rises at the edge after the final Wen cycle. It is never high while Wen=1.
- matrix_valid falls at the edge that samples release=1 in FULL.
- The next start can be accepted the cycle after matrix_valid falls.

## Configuration
- MATRIX_LOADER_TRANSPOSE_EN
  - Defined: transpose is sampled with start. If it is 1, that load uses the transposed mapping, so in_data arrives column by column.
  - Not defined: the transpose port is present but ignored, and the latched value is tied to 0. All loads are row-major.

## Test plan
- Reset, then start, then 64 back-to-back words 0x0000..0x003F:
  - Wen is high for exactly 64 consecutive cycles.
  - Word k is written at Wi=k>>3, Wj=k&7; RAM word[k]=k.
  - matrix_valid rises 1 cycle after the last Wen.
  - words_loaded=64.
- Same stream with in_valid low on every 3rd cycle:
  - No duplicate or skipped address.
  - Wen=0 exactly on the stall cycles.
  - Final RAM contents identical to the back-to-back test.
- Macro defined, transpose=1 at start, words 0x0100+k:
  - Word k is written at Wi=k&7, Wj=k>>3; RAM word[8*(k&7)+(k>>3)]=0x0100+k.
  - Macro undefined, same stimulus: mapping is row-major.
- Reset asserted after the 20th transfer:
  - Next cycle: Wen=0, in_ready=0, words_loaded=0, all outputs 0.
  - A new start plus 64 words completes normally.
- In FULL: in_valid=1 held, and start pulsed:
  - in_ready stays 0; no Wen; matrix_valid stays 1.
- In FULL: release and start asserted together → IDLE, matrix_valid=0. start must be re-pulsed to load again.

Source files
------------

// File: rtl/matrix_loader_if.sv
// Stream and RAM write-port bundle for matrix_loader.
// release_i carries the consumer's release request (plain "release" is a
// reserved word in SystemVerilog).
interface matrix_loader_if #(
  parameter int SIZE = 16
);
  logic            start;
  logic            transpose;
  logic [SIZE-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] W_data;
  logic [2:0]      Wi_address;
  logic [2:0]      Wj_address;
  logic            Wen;
  logic [6:0]      words_loaded;
  logic            matrix_valid;
  logic            release_i;

  // Stream source / consumer side.
  modport master (
    output start, transpose, in_data, in_valid, release_i,
    input  in_ready, W_data, Wi_address, Wj_address, Wen,
           words_loaded, matrix_valid
  );

  // Loader side.
  modport slave (
    input  start, transpose, in_data, in_valid, release_i,
    output in_ready, W_data, Wi_address, Wj_address, Wen,
           words_loaded, matrix_valid
  );
endinterface

// File: rtl/matrix_loader.sv
// matrix_loader: write-side sequencer for the 8x8 coefficient RAM.
// Accepts 64 words over valid/ready and writes them row-major, or
// transposed when built with MATRIX_LOADER_TRANSPOSE_EN and transpose=1
// at start. Then holds the matrix (matrix_valid) until released.
//
// state | meaning
// IDLE  | waiting for start, no writes
// LOAD  | accepting words, one RAM write per transfer
// FLUSH | last write on the RAM port, stream closed
// FULL  | matrix complete and stable, waiting for release
module matrix_loader #(
  parameter int SIZE = 16
) (
  input logic            clock,
  input logic            reset,
  matrix_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, FULL} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] wdata_q, wdata_d;
  logic [2:0]      wi_q, wi_d;
  logic [2:0]      wj_q, wj_d;
  logic            wen_q, wen_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            mv_q, mv_d;
  logic            tr_q, tr_d;
  logic [5:0]      k;

  assign k = cnt_q[5:0];

`ifndef MATRIX_LOADER_TRANSPOSE_EN
  logic unused_transpose;
  assign unused_transpose = bus.transpose;
`endif

  // State and output registers; reset abandons any partial load.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wdata_q <= '0;
      wi_q    <= 3'd0;
      wj_q    <= 3'd0;
      wen_q   <= 1'b0;
      cnt_q   <= 7'd0;
      mv_q    <= 1'b0;
      tr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      wi_q    <= wi_d;
      wj_q    <= wj_d;
      wen_q   <= wen_d;
      cnt_q   <= cnt_d;
      mv_q    <= mv_d;
      tr_q    <= tr_d;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    wi_d    = wi_q;
    wj_d    = wj_q;
    wen_d   = 1'b0;
    cnt_d   = cnt_q;
    mv_d    = mv_q;
    tr_d    = tr_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          cnt_d   = 7'd0;
`ifdef MATRIX_LOADER_TRANSPOSE_EN
          tr_d    = bus.transpose;
`else
          tr_d    = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          wdata_d = bus.in_data;
          wen_d   = 1'b1;
          cnt_d   = cnt_q + 7'd1;
          if (tr_q) begin
            wi_d = k[2:0];
            wj_d = k[5:3];
          end else begin
            wi_d = k[5:3];
            wj_d = k[2:0];
          end
          if (k == 6'd63) state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = FULL;
        mv_d    = 1'b1;
      end
      FULL: begin
        // release wins over a simultaneous start; start is dropped.
        if (bus.release_i) begin
          state_d = IDLE;
          mv_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready     = (state_q == LOAD);
  assign bus.W_data       = wdata_q;
  assign bus.Wi_address   = wi_q;
  assign bus.Wj_address   = wj_q;
  assign bus.Wen          = wen_q;
  assign bus.words_loaded = cnt_q;
  assign bus.matrix_valid = mv_q;

endmodule
